// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM states and counter sizing.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter width for ncyc steps; never narrower than one bit.
  function automatic int cnt_width(input int ncyc);
    return (ncyc <= 1) ? 1 : $clog2(ncyc);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, chained by serial_adder to form each step slice.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds STEP bits per clock through a fulladder ripple chain,
// carrying between cycles in a flop, with a start/busy/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NCYC = WIDTH / STEP;
  localparam int CW   = cnt_width(NCYC);
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next, step_ext;
  logic             carry;
  logic [CW-1:0]    count;
  logic [STEP:0]    chain_c;
  logic [STEP-1:0]  step_sum;
  logic             accept;
  logic             last_step;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (count == LAST);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  assign chain_c[0] = carry;

  genvar i;
  generate
    for (i = 0; i < STEP; i++) begin : g_chain
      fulladder u_fa (
        .a  (a_sr[i]),
        .b  (b_sr[i]),
        .ci (chain_c[i]),
        .s  (step_sum[i]),
        .co (chain_c[i+1])
      );
    end
  endgenerate

  // New result bits enter from the MSB side so bit 0 lands at res_sr[0] last.
  assign step_ext = WIDTH'(step_sum);
  assign res_next = (res_sr >> STEP) | (step_ext << (WIDTH - STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sum/co are only written on the final step, so they hold through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      co     <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      carry  <= ci;
      count  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> STEP;
      b_sr   <= b_sr >> STEP;
      res_sr <= res_next;
      carry  <= chain_c[STEP];
      count  <= count + 1'b1;
      if (last_step) begin
        sum <= res_next;
        co  <= chain_c[STEP];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across several WIDTH/STEP configurations.
module tb_serial_adder;

  typedef struct {
    logic [8:0] val;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_v [5];
  logic [7:0] a_v [5];
  logic [7:0] b_v [5];
  logic       ci_v [5];
  logic       busy_v [5];
  logic       done_v [5];
  logic       co_v [5];
  logic [7:0] s0, s2, s3, s4;
  logic [3:0] s1;
  logic [8:0] res_v [5];

  exp_t sb [5][$];
  int   ncyc [5];
  int   cyc;
  int   checks;
  int   errors;

  // Instances: 0=(8,1) 1=(4,1) 2=(8,2) 3=(8,4) 4=(8,8)
  serial_adder #(.WIDTH(8), .STEP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .ci(ci_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .co(co_v[0]));
  serial_adder #(.WIDTH(4), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .ci(ci_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .co(co_v[1]));
  serial_adder #(.WIDTH(8), .STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .ci(ci_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .co(co_v[2]));
  serial_adder #(.WIDTH(8), .STEP(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]), .ci(ci_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .co(co_v[3]));
  serial_adder #(.WIDTH(8), .STEP(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .a(a_v[4]), .b(b_v[4]), .ci(ci_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .sum(s4), .co(co_v[4]));

  assign res_v[0] = {co_v[0], s0};
  assign res_v[1] = {4'b0, co_v[1], s1};
  assign res_v[2] = {co_v[2], s2};
  assign res_v[3] = {co_v[3], s3};
  assign res_v[4] = {co_v[4], s4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a start at the current negedge; the accepting edge is the next posedge.
  task automatic apply_stimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                                input logic ci, input logic [8:0] exp, input bit push);
    exp_t e;
    start_v[d] = 1'b1;
    a_v[d]     = a;
    b_v[d]     = b;
    ci_v[d]    = ci;
    if (push) begin
      e.val = exp;
      e.cyc = cyc + 1 + ncyc[d];
      sb[d].push_back(e);
    end
    @(negedge clk);
    start_v[d] = 1'b0;
    a_v[d]     = 8'hxx;
    b_v[d]     = 8'hxx;
    ci_v[d]    = 1'bx;
  endtask

  task automatic wait_done(input int d, input string name);
    for (int i = 0; i < 20 && !done_v[d]; i++) @(negedge clk);
    check_output(name, {8'h0, done_v[d]}, 9'h1);
  endtask

  // Monitor: pops the scoreboard whenever any instance presents done.
  initial begin
    bit   prev_done [5];
    exp_t e;
    for (int d = 0; d < 5; d++) prev_done[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 5; d++) begin
        if (done_v[d] === 1'b1) begin
          check_output($sformatf("done_pulse_width_%0d", d), {8'h0, prev_done[d]}, 9'h0);
          checks++;
          if (sb[d].size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_done_%0d got done=1 expected no result pending", d);
          end else begin
            e = sb[d].pop_front();
            check_output($sformatf("result_%0d", d), res_v[d], e.val);
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("[TB] FAIL latency_%0d got cycle %0d expected cycle %0d", d, cyc, e.cyc);
            end
          end
        end
        prev_done[d] = (done_v[d] === 1'b1);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    ncyc[0] = 8; ncyc[1] = 4; ncyc[2] = 4; ncyc[3] = 2; ncyc[4] = 1;
    for (int d = 0; d < 5; d++) begin
      start_v[d] = 1'b0;
      a_v[d] = 8'h00;
      b_v[d] = 8'h00;
      ci_v[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      check_output($sformatf("reset_result_%0d", d), res_v[d], 9'h0);
      check_output($sformatf("reset_flags_%0d", d), {7'h0, busy_v[d], done_v[d]}, 9'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Ignored mid-RUN start, then a start accepted during the DONE cycle.
    apply_stimulus(0, 8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    check_output("busy_after_start", {8'h0, busy_v[0]}, 9'h1);
    @(negedge clk);
    apply_stimulus(0, 8'hFF, 8'h34, 1'b0, 9'h000, 1'b0);
    wait_done(0, "done_seen_ignored_start");
    apply_stimulus(0, 8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
    check_output("busy_after_done_start", {8'h0, busy_v[0]}, 9'h1);
    repeat (12) @(negedge clk);
    check_output("sum_hold_idle", res_v[0], 9'h002);

    // Asynchronous reset in the middle of an operation.
    apply_stimulus(0, 8'hFF, 8'h01, 1'b0, 9'h000, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_result", res_v[0], 9'h0);
    check_output("abort_flags", {7'h0, busy_v[0], done_v[0]}, 9'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(0, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    repeat (12) @(negedge clk);

    // Chunked and degenerate step sizes.
    fork
      apply_stimulus(2, 8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
      apply_stimulus(3, 8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
      apply_stimulus(4, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
    join
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_output("degenerate_hold", res_v[4], 9'h100);
      @(negedge clk);
    end

    // Exhaustive 4-bit sweep, issued back-to-back in each DONE cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          apply_stimulus(1, 8'(a), 8'(b), c[0], 9'(a + b + c), 1'b1);
          wait_done(1, "done_seen_sweep");
        end
      end
    end
    repeat (15) @(negedge clk);

    for (int d = 0; d < 5; d++)
      check_output($sformatf("pending_results_%0d", d), 9'(sb[d].size()), 9'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, STEP bits per clock.
- Built from a chain of fulladder cells, with a registered carry between cycles and a start/done handshake.
- Successor to the combinational single-bit fulladder. Used by datapaths that trade latency for area.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be >= 1.
- STEP, 1, bits added per clock; must divide WIDTH exactly. NCYC = WIDTH/STEP.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block can accept a new operation
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- ci  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum/co valid
- sum  output  WIDTH  result, held until the next accepted start
- co  output  1  final carry-out, held with sum

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, co=0.
  - Internal operand shift registers, carry flop and cycle counter all cleared.
  - Reset mid-RUN aborts the operation; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch a, b, ci; count=0; state->RUN; busy=1.
  - start=0: remain in IDLE.
- RUN:
  - Each edge adds the low STEP bits of the A/B shift registers plus the carry flop through the STEP-cell fulladder chain.
  - STEP result bits are shifted into sum from the MSB side, so after NCYC cycles bit 0 ends at sum[0].
  - Chain carry-out goes into the carry flop; A/B shift right by STEP; count increments.
  - At the edge where count reaches NCYC-1 (edge E_NCYC): state->DONE, busy=0, done=1, co=carry-out of that step.
- DONE (one cycle):
  - done=1; sum/co valid.
  - Next edge: if start=1, accept a new operation exactly as from IDLE (done->0, busy->1). Otherwise state->IDLE, done->0.
- start while in RUN is ignored; it is neither queued nor re-latched later.
- Operand inputs are don't-care outside the accepting edge.
- Latency: done high during the cycle after edge E_NCYC, i.e. NCYC edges after the start edge.
- Back-to-back throughput: one result every NCYC+1 cycles.
- sum and co hold their last values in IDLE, and in RUN until the final step overwrites them.
- Arithmetic is unsigned modulo 2^WIDTH: {co,sum} = a + b + ci, with no overflow flag.
- Degenerate case STEP=WIDTH: NCYC=1, done high one edge after start.

Decomposition:
- Shared package (adder_pkg):
  - state enum (IDLE, RUN, DONE).
  - Function computing the counter width, clog2 of NCYC with a minimum of 1.
- Sub-module: the existing fulladder, instantiated STEP times as a ripple chain in a generate loop. No other sub-modules.

Test Plan:
- Reset mid-RUN:
  - WIDTH=8, STEP=1: start with a=8'hFF, b=8'h01, ci=0.
  - Drive rst_n low at cycle 4 -> busy=0, done=0, sum=0, co=0 immediately.
  - Release rst_n, restart the same operands -> done exactly 8 edges after start, sum=8'h00, co=1.
- Exhaustive, WIDTH=4, STEP=1: all a, b, ci combinations (512) -> {co,sum}==a+b+ci at every done; done width is exactly 1 cycle.
- Chunked steps, WIDTH=8, STEP=2: a=8'hA5, b=8'h5A, ci=1 -> done after 4 edges, sum=8'h00, co=1.
  - Same operands with STEP=4 -> done after 2 edges, same result.
- Ignored start, WIDTH=8, STEP=1:
  - a=8'h12, b=8'h34, ci=0; re-pulse start with a=8'hFF in cycle 3 -> ignored; done after 8 edges, sum=8'h46, co=0.
  - Assert start during the DONE cycle with a=8'h01, b=8'h01 -> accepted; busy next cycle; second done gives sum=8'h02.
- Degenerate STEP=WIDTH=8: a=8'h80, b=8'h80, ci=0 -> done one edge after start, sum=8'h00, co=1; sum/co hold through 5 idle cycles.
